// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-N demultiplexer with valid/ready on both sides.
//
// One input stream is steered to one of N_OUT output channels by a per-beat
// select. Each channel owns a single registered entry. A stalled channel
// therefore never blocks beats bound for other channels, and a channel that
// stays ready sustains one beat per cycle.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rstn   - synchronous active-low reset
//   i_valid  - input beat present
//   o_ready  - input beat accepted when high together with i_valid
//   i_sel    - destination channel of the current beat
//   i_data   - input payload
//   o_valid  - per-channel entry valid
//   i_ready  - per-channel downstream ready
//   o_data   - per-channel payload, channel k at [k*DATA_W +: DATA_W]
//   o_err    - one-cycle pulse after an out-of-range beat is dropped
//   o_cnt    - per-channel 16-bit drain counters, channel k at [k*16 +: 16]
//
// Optional feature: define DEMUX_REG_CNT_EN to build the drain counters.
// Without it, o_cnt is tied to zero and the port list is unchanged.
module demux_reg #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [DATA_W-1:0]        i_data,
  output logic [N_OUT-1:0]         o_valid,
  input  logic [N_OUT-1:0]         i_ready,
  output logic [N_OUT*DATA_W-1:0]  o_data,
  output logic                     o_err,
  output logic [N_OUT*16-1:0]      o_cnt
);

  logic [N_OUT-1:0]        valid_q, valid_d;
  logic [N_OUT*DATA_W-1:0] data_q, data_d;
  logic                    err_q, err_d;

  logic [N_OUT-1:0]        sel_oh;
  logic                    in_range;
  logic                    accept;
  logic [N_OUT-1:0]        fill;
  logic [N_OUT-1:0]        drain;

  // One-hot decode of the select. A select that matches no channel leaves
  // the vector all zero, which is how out-of-range beats are recognised;
  // this avoids indexing o_valid with a value that may exceed N_OUT-1.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_oh[k] = (i_sel == SEL_W'(k));
    end
  end

  // Ready only looks at the addressed channel: it can take a beat when it
  // is empty or is draining this cycle. Out-of-range beats are always taken
  // so they can be dropped. i_valid is deliberately not involved.
  always_comb begin
    in_range = |sel_oh;
    o_ready  = !in_range || (|(sel_oh & (~valid_q | i_ready)));
    accept   = i_valid && o_ready;
    fill     = sel_oh & {N_OUT{accept}};
    drain    = valid_q & i_ready;
  end

  // Next entry state. A fill wins over a drain of the same channel so the
  // entry is replaced in place and valid stays high for full throughput.
  // A drain without fill clears valid but leaves the last data in place.
  always_comb begin
    valid_d = (valid_q & ~drain) | fill;
    data_d  = data_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (fill[k]) begin
        data_d[k*DATA_W +: DATA_W] = i_data;
      end
    end
    err_d = accept && !in_range;
  end

  // Entry, data and error registers with synchronous reset taking priority
  // over any accept or drain in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_err   = err_q;

`ifdef DEMUX_REG_CNT_EN
  logic [N_OUT*16-1:0] cnt_q, cnt_d;

  // Each counter counts drains of its channel and wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (drain[k]) begin
        cnt_d[k*16 +: 16] = cnt_q[k*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: directed self-checking bench for demux_reg.
//
// Two instances share clock and reset: a default 4-channel instance for the
// main behaviour and a 3-channel instance with a 2-bit select so that
// select value 3 is out of range.
module tb_demux_reg;

  logic        i_clk;
  logic        i_rstn;

  // Four-channel instance signals
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_sel;
  logic [7:0]  i_data;
  logic [3:0]  o_valid;
  logic [3:0]  i_ready;
  logic [31:0] o_data;
  logic        o_err;
  logic [63:0] o_cnt;

  // Three-channel instance signals
  logic        b_valid;
  logic        b_o_ready;
  logic [1:0]  b_sel;
  logic [7:0]  b_data;
  logic [2:0]  b_o_valid;
  logic [2:0]  b_ready;
  logic [23:0] b_o_data;
  logic        b_o_err;
  logic [47:0] b_o_cnt;

  int checks;
  int failures;

  demux_reg #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sel   (i_sel),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_err   (o_err),
    .o_cnt   (o_cnt)
  );

  demux_reg #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) dut3 (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_valid (b_valid),
    .o_ready (b_o_ready),
    .i_sel   (b_sel),
    .i_data  (b_data),
    .o_valid (b_o_valid),
    .i_ready (b_ready),
    .o_data  (b_o_data),
    .o_err   (b_o_err),
    .o_cnt   (b_o_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock edge and settle so registered outputs can be sampled.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn  = 1'b0;
    i_valid = 1'b1;
    i_sel   = 2'd0;
    i_data  = 8'h77;
    i_ready = 4'b0000;
    b_valid = 1'b1;
    b_sel   = 2'd1;
    b_data  = 8'h66;
    b_ready = 3'b000;
    repeat (3) step();
    checks++;
    if (o_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_valid got=%b exp=%b", o_valid, 4'b0000);
    end
    checks++;
    if (o_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=%h", o_data, 32'h0);
    end
    checks++;
    if (o_err !== 1'b0 || o_cnt !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_err_cnt got err=%b cnt=%h exp err=0 cnt=0", o_err, o_cnt);
    end
    checks++;
    if (b_o_valid !== 3'b000 || b_o_data !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_dut3 got valid=%b data=%h exp 0/0", b_o_valid, b_o_data);
    end
    i_rstn  = 1'b1;
    i_valid = 1'b0;
    b_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_release_valid got=%b exp=%b", o_valid, 4'b0000);
    end
  endtask

  task automatic test_basic_routing();
    logic [3:0] exp_v;
    logic [7:0] exp_d;
    i_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_sel   = 2'(k);
      i_data  = 8'h10 + 8'(k);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL basic_ready ch=%0d got=%b exp=1", k, o_ready);
      end
      step();
      exp_v = 4'b0001 << k;
      exp_d = 8'h10 + 8'(k);
      checks++;
      if (o_valid !== exp_v || o_data[k*8 +: 8] !== exp_d) begin
        failures++;
        $display("[TB] FAIL basic_route ch=%0d got valid=%b data=%h exp valid=%b data=%h",
                 k, o_valid, o_data[k*8 +: 8], exp_v, exp_d);
      end
    end
    i_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 4'b0000 || o_data !== 32'h13121110 || o_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_drained got valid=%b data=%h err=%b exp 0000/13121110/0",
               o_valid, o_data, o_err);
    end
    checks++;
`ifdef DEMUX_REG_CNT_EN
    if (o_cnt !== 64'h0001_0001_0001_0001) begin
      failures++;
      $display("[TB] FAIL basic_cnt got=%h exp=%h", o_cnt, 64'h0001_0001_0001_0001);
    end
`else
    if (o_cnt !== 64'h0) begin
      failures++;
      $display("[TB] FAIL basic_cnt got=%h exp=%h", o_cnt, 64'h0);
    end
`endif
  endtask

  task automatic test_backpressure();
    i_ready = 4'b1011;
    i_valid = 1'b1;
    i_sel   = 2'd2;
    i_data  = 8'hA5;
    step();
    i_data = 8'h5A;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_ready_low got=%b exp=0", o_ready);
    end
    step();
    checks++;
    if (o_valid[2] !== 1'b1 || o_data[23:16] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL bp_hold got valid=%b data=%h exp 1/a5", o_valid[2], o_data[23:16]);
    end
    i_sel  = 2'd1;
    i_data = 8'h3C;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_other_ready got=%b exp=1", o_ready);
    end
    step();
    checks++;
    if (o_valid !== 4'b0110 || o_data[15:8] !== 8'h3C || o_data[23:16] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL bp_other_accept got valid=%b data=%h exp valid=0110 ch1=3c ch2=a5",
               o_valid, o_data);
    end
    i_sel  = 2'd2;
    i_data = 8'h5A;
    i_ready = 4'b1111;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release_ready got=%b exp=1", o_ready);
    end
    step();
    checks++;
    if (o_valid !== 4'b0100 || o_data[23:16] !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL bp_release got valid=%b ch2=%h exp 0100/5a", o_valid, o_data[23:16]);
    end
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_same_cycle_drain_fill();
    i_ready = 4'b0000;
    i_valid = 1'b1;
    i_sel   = 2'd3;
    i_data  = 8'h11;
    step();
    checks++;
    if (o_valid[3] !== 1'b1 || o_data[31:24] !== 8'h11) begin
      failures++;
      $display("[TB] FAIL sdf_first got valid=%b data=%h exp 1/11", o_valid[3], o_data[31:24]);
    end
    i_ready = 4'b1000;
    i_data  = 8'h22;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sdf_ready got=%b exp=1", o_ready);
    end
    step();
    checks++;
    if (o_valid[3] !== 1'b1 || o_data[31:24] !== 8'h22) begin
      failures++;
      $display("[TB] FAIL sdf_replace got valid=%b data=%h exp 1/22", o_valid[3], o_data[31:24]);
    end
    i_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 4'b0000 || o_data[31:24] !== 8'h22) begin
      failures++;
      $display("[TB] FAIL sdf_drain got valid=%b data=%h exp 0000/22", o_valid, o_data[31:24]);
    end
  endtask

  task automatic test_out_of_range();
    b_ready = 3'b000;
    b_valid = 1'b1;
    b_sel   = 2'd1;
    b_data  = 8'h42;
    step();
    b_sel  = 2'd3;
    b_data = 8'hFF;
    #1;
    checks++;
    if (b_o_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oor_ready got=%b exp=1", b_o_ready);
    end
    step();
    checks++;
    if (b_o_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oor_err_pulse got=%b exp=1", b_o_err);
    end
    checks++;
    if (b_o_valid !== 3'b010 || b_o_data !== 24'h004200) begin
      failures++;
      $display("[TB] FAIL oor_no_change got valid=%b data=%h exp 010/004200", b_o_valid, b_o_data);
    end
    b_valid = 1'b0;
    step();
    checks++;
    if (b_o_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oor_err_clear got=%b exp=0", b_o_err);
    end
    b_ready = 3'b111;
    step();
  endtask

  task automatic test_counters();
    i_rstn  = 1'b0;
    i_valid = 1'b0;
    step();
    i_rstn  = 1'b1;
    i_ready = 4'b1111;
    i_sel   = 2'd0;
    i_data  = 8'h01;
`ifdef DEMUX_REG_CNT_EN
    i_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      step();
    end
    i_valid = 1'b0;
    step();
    checks++;
    if (o_cnt !== 64'h0000_0000_0000_0001) begin
      failures++;
      $display("[TB] FAIL cnt_wrap got=%h exp=%h", o_cnt, 64'h1);
    end
`else
    i_valid = 1'b1;
    repeat (20) step();
    i_valid = 1'b0;
    step();
    checks++;
    if (o_cnt !== 64'h0) begin
      failures++;
      $display("[TB] FAIL cnt_disabled got=%h exp=%h", o_cnt, 64'h0);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_routing();
    test_backpressure();
    test_same_cycle_drain_fill();
    test_out_of_range();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
# demux_reg

Registered 1-to-N demultiplexer with valid/ready handshake on both sides. It is the routing counterpart of the 2:1 multiplexers in the combination library: one input stream is steered to one of `N_OUT` output channels by a per-beat select. Each output channel holds one registered entry, so a stalled channel never blocks beats bound for other channels, and a continuously ready channel sustains one beat per cycle.

## Interface
Parameters:
- `DATA_W`, default 8: payload width.
- `N_OUT`, default 4: number of output channels, 2..16. Need not be a power of two.
- `SEL_W`, default 2: select width, must satisfy 2^SEL_W >= N_OUT.

Ports:
- `i_clk`, input, 1: clock. All logic is on the rising edge.
- `i_rstn`, input, 1: synchronous, active-low reset.
- `i_valid`, input, 1: input beat present.
- `o_ready`, output, 1: input beat accepted this cycle when high together with `i_valid`.
- `i_sel`, input, SEL_W: destination channel of the current beat.
- `i_data`, input, DATA_W: payload.
- `o_valid`, output, N_OUT: per-channel entry valid.
- `i_ready`, input, N_OUT: per-channel downstream ready.
- `o_data`, output, N_OUT*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- `o_err`, output, 1: one-cycle pulse when an out-of-range beat is dropped.
- `o_cnt`, output, N_OUT*16: per-channel transfer counters, channel k occupies [k*16 +: 16]. See Configuration.

## Operation
- Per-channel entry state is EMPTY (`o_valid[k]`=0) or FULL (`o_valid[k]`=1). There is no other FSM.
- Drain: channel k drains in a cycle where `o_valid[k]` && `i_ready[k]`.
- Ready, in-range select (`i_sel` < N_OUT): `o_ready` = !`o_valid[i_sel]` || `i_ready[i_sel]`. This is combinational from `i_sel`, `o_valid` and `i_ready`, with no dependency on `i_valid`.
- Ready, out-of-range select (`i_sel` >= N_OUT): `o_ready` = 1. The beat is discarded and no channel changes.
- Accept (`i_valid` && `o_ready`, in range): on the next edge, `o_data[sel]` <= `i_data` and `o_valid[sel]` <= 1.
- Drain without fill: `o_valid[k]` <= 0. `o_data[k]` holds its last value.
- Simultaneous drain and fill of the same channel: the entry is replaced and `o_valid` stays 1. This gives full throughput.
- Multiple channels may drain in the same cycle. Only one channel can fill per cycle.
- `o_err`: registered. It is 1 in the cycle after an accepted out-of-range beat, and 0 otherwise.
- Order: beats to the same channel leave in acceptance order. No ordering holds across channels.

## Timing
- Latency: a beat accepted at edge t is visible on `o_valid`/`o_data` of its channel after edge t, i.e. in cycle t+1.
- `o_ready` is combinational. `o_valid`, `o_data`, `o_err` and `o_cnt` are registered.
- Reset (`i_rstn`=0 at an edge) clears all of `o_valid`, `o_data`, `o_err` and `o_cnt` to 0. Reset overrides any simultaneous accept or drain. During reset `o_ready` follows its equation, but no beat is taken.
- Reset mid-operation: all held entries are lost and no drain is reported.
- A FULL channel with `i_ready[k]`=0 holds `o_valid` and `o_data` stable until it drains. No data changes while valid is high and ready is low.

## Configuration
- Macro `DEMUX_REG_CNT_EN`.
- Defined: `o_cnt[k]` increments by 1 on every drain of channel k and wraps from 0xFFFF to 0x0000. It is cleared by reset.
- Not defined: the counter registers are not built and `o_cnt` is tied to all zeros. The port list is unchanged.

## Test plan
- Reset: hold `i_rstn`=0 for 3 cycles with `i_valid`=1 -> all outputs 0 and no entry captured. After release, `o_valid`=4'b0000.
- Basic routing: all `i_ready`=1; send `i_sel`=0..3 with `i_data`=0x10..0x13 back-to-back -> channel k shows 0x1k exactly one cycle after its beat. `o_ready` stays 1 throughout.
- Backpressure: `i_ready[2]`=0; send 0xA5 then 0x5A to channel 2 -> 0xA5 is held and `o_ready`=0 for the second beat until `i_ready[2]`=1. A beat to channel 1 in the meantime is accepted immediately.
- Same-cycle drain and fill: channel 3 FULL with 0x11, `i_ready[3]`=1, new beat 0x22 to channel 3 -> next cycle `o_valid[3]`=1 and data is 0x22.
- Out of range: `N_OUT`=3, `SEL_W`=2, `i_sel`=3, `i_data`=0xFF -> `o_ready`=1, `o_err`=1 for one cycle, and no `o_valid` changes.
- Counters (macro defined): 65537 drains on channel 0 -> `o_cnt[0]`=1, other channels 0. With the macro undefined, `o_cnt` stays 0.
